// File: rtl/cbs_pkg.sv
// Shared types and constants for the CBS output link observer.
// Frame FSM states, default widths and a bytes-per-beat helper.
package cbs_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_USER_WIDTH = 1;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH  = 32;

  function automatic int bytes_per_beat(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// Two-entry register slice: output register plus one skid register.
// Upstream ready is the skid-empty flag, so it never depends on m_ready.
module axis_skid_slice #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_v;
  logic             skid_v;
  logic             acc;
  logic             drain;

  // Handshake qualifiers for this cycle.
  always_comb begin
    s_ready = ~skid_v;
    acc     = s_valid & ~skid_v;
    drain   = out_v & m_ready;
  end

  // Output register refills from skid first, then from upstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (drain || !out_v) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= acc;
        if (acc) begin
          out_q <= s_data;
        end
      end
    end else if (acc) begin
      skid_q <= s_data;
      skid_v <= 1'b1;
    end
  end

  assign m_data  = out_q;
  assign m_valid = out_v;

endmodule

// File: rtl/cbs_output_link_observer.sv
// AXI4-Stream skid pass-through with output-side frame tracking.
// Define CBS_LINK_OBS_STATS_EN to build the stall/idle counters.
module cbs_output_link_observer
  import cbs_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  output_side_ready,
  output logic                  tx_active,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic [LEN_WIDTH-1:0]  frame_bytes,
  input  logic                  stats_clear,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic [CNT_WIDTH-1:0]  idle_cycles
);

  localparam int PW  = DATA_WIDTH + USER_WIDTH + 1;
  localparam int BPB = bytes_per_beat(DATA_WIDTH);

  localparam logic [LEN_WIDTH:0] LEN_MAX =
    {1'b0, {LEN_WIDTH{1'b1}}};
  localparam logic [LEN_WIDTH:0] BPB_EXT =
    (LEN_WIDTH+1)'(BPB);
  localparam logic [LEN_WIDTH:0] FIRST_EXT =
    (BPB_EXT > LEN_MAX) ? LEN_MAX : BPB_EXT;

  logic [PW-1:0]        s_pl;
  logic [PW-1:0]        m_pl;
  logic                 beat;
  frame_state_t         state_q;
  frame_state_t         state_d;
  logic                 start_d;
  logic                 end_d;
  logic [LEN_WIDTH-1:0] byte_cnt;
  logic [LEN_WIDTH-1:0] cur_bytes;
  logic [LEN_WIDTH:0]   sum;

  assign s_pl = {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  axis_skid_slice #(
    .WIDTH (PW)
  ) u_slice (
    .clk     (clk),
    .rstn    (rstn),
    .s_data  (s_pl),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_pl),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tdata = m_pl[DATA_WIDTH-1:0];
  assign m_axis_tlast = m_pl[DATA_WIDTH];
  assign m_axis_tuser = m_pl[PW-1:DATA_WIDTH+1];

  assign output_side_ready = m_axis_tready;
  assign beat = m_axis_tvalid & m_axis_tready;

  // Running byte count including the current beat, saturating.
  always_comb begin
    sum = {1'b0, byte_cnt} + BPB_EXT;
    if (state_q == IDLE) begin
      cur_bytes = FIRST_EXT[LEN_WIDTH-1:0];
    end else if (sum > LEN_MAX) begin
      cur_bytes = LEN_MAX[LEN_WIDTH-1:0];
    end else begin
      cur_bytes = sum[LEN_WIDTH-1:0];
    end
  end

  // Frame FSM next state and boundary pulses.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          start_d = 1'b1;
          if (m_axis_tlast) begin
            end_d = 1'b1;
          end else begin
            state_d = IN_FRAME;
          end
        end
      end
      IN_FRAME: begin
        if (beat && m_axis_tlast) begin
          end_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_active = (state_q == IN_FRAME) |
                     ((state_q == IDLE) & beat);

  // Frame state, registered pulses and byte length.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      byte_cnt    <= '0;
      frame_bytes <= '0;
    end else begin
      state_q     <= state_d;
      frame_start <= start_d;
      frame_end   <= end_d;
      if (beat) begin
        byte_cnt <= cur_bytes;
        if (m_axis_tlast) begin
          frame_bytes <= cur_bytes;
        end
      end
    end
  end

`ifdef CBS_LINK_OBS_STATS_EN
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] idle_q;

  // Saturating stall/idle counters; clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
      idle_q  <= '0;
    end else if (stats_clear) begin
      stall_q <= '0;
      idle_q  <= '0;
    end else begin
      if (m_axis_tvalid && !m_axis_tready &&
          stall_q != '1) begin
        stall_q <= stall_q + 1'b1;
      end
      if (!m_axis_tvalid && idle_q != '1) begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign idle_cycles  = idle_q;
`else
  logic unused_stats_clear;

  assign unused_stats_clear = stats_clear;
  assign stall_cycles       = '0;
  assign idle_cycles        = '0;
`endif

endmodule

// File: tb/tb_cbs_output_link_observer.sv
// Directed bench for cbs_output_link_observer.
// Default instance (8-bit) plus a 32-bit/LEN 4 instance.
module tb_cbs_output_link_observer;

`ifdef CBS_LINK_OBS_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [0:0]  s_user;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [0:0]  m_user;
  logic        osr;
  logic        tx_active;
  logic        fs;
  logic        fe;
  logic [15:0] fb;
  logic        clr;
  logic [31:0] stall;
  logic [31:0] idle;

  logic [31:0] w_s_data;
  logic        w_s_valid;
  logic        w_s_ready;
  logic        w_s_last;
  logic [0:0]  w_s_user;
  logic [31:0] w_m_data;
  logic        w_m_valid;
  logic        w_m_ready;
  logic        w_m_last;
  logic [0:0]  w_m_user;
  logic        w_osr;
  logic        w_tx;
  logic        w_fs;
  logic        w_fe;
  logic [3:0]  w_fb;
  logic [31:0] w_stall;
  logic [31:0] w_idle;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];

  cbs_output_link_observer dut (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis_tdata      (s_data),
    .s_axis_tvalid     (s_valid),
    .s_axis_tready     (s_ready),
    .s_axis_tlast      (s_last),
    .s_axis_tuser      (s_user),
    .m_axis_tdata      (m_data),
    .m_axis_tvalid     (m_valid),
    .m_axis_tready     (m_ready),
    .m_axis_tlast      (m_last),
    .m_axis_tuser      (m_user),
    .output_side_ready (osr),
    .tx_active         (tx_active),
    .frame_start       (fs),
    .frame_end         (fe),
    .frame_bytes       (fb),
    .stats_clear       (clr),
    .stall_cycles      (stall),
    .idle_cycles       (idle)
  );

  cbs_output_link_observer #(
    .DATA_WIDTH (32),
    .LEN_WIDTH  (4)
  ) dut_w (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis_tdata      (w_s_data),
    .s_axis_tvalid     (w_s_valid),
    .s_axis_tready     (w_s_ready),
    .s_axis_tlast      (w_s_last),
    .s_axis_tuser      (w_s_user),
    .m_axis_tdata      (w_m_data),
    .m_axis_tvalid     (w_m_valid),
    .m_axis_tready     (w_m_ready),
    .m_axis_tlast      (w_m_last),
    .m_axis_tuser      (w_m_user),
    .output_side_ready (w_osr),
    .tx_active         (w_tx),
    .frame_start       (w_fs),
    .frame_end         (w_fe),
    .frame_bytes       (w_fb),
    .stats_clear       (clr),
    .stall_cycles      (w_stall),
    .idle_cycles       (w_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rstn && m_valid && m_ready) begin
      rx_q.push_back(m_data);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    s_user    = '0;
    m_ready   = 1'b1;
    clr       = 1'b0;
    w_s_data  = '0;
    w_s_valid = 1'b0;
    w_s_last  = 1'b0;
    w_s_user  = '0;
    w_m_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_user", 32'(m_user), 0);
    chk("rst_tx_active", 32'(tx_active), 0);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_fe", 32'(fe), 0);
    chk("rst_fb", 32'(fb), 0);
    chk("rst_stall", stall, 0);
    chk("rst_idle", idle, 0);
    #2 rstn = 1'b1;
    step();
    chk("rel_s_ready", 32'(s_ready), 1);
    chk("rel_idle", idle, STATS ? 1 : 0);

    // 4-beat frame, ready held high
    for (int i = 0; i < 4; i++) begin
      s_data  = 8'hA0 + 8'(i);
      s_last  = (i == 3);
      s_user  = 1'(i);
      s_valid = 1'b1;
      step();
      chk("t1_m_valid", 32'(m_valid), 1);
      chk("t1_m_data", 32'(m_data), 32'(8'hA0 + 8'(i)));
      chk("t1_m_last", 32'(m_last), (i == 3) ? 1 : 0);
      chk("t1_m_user", 32'(m_user), 32'(i % 2));
      chk("t1_s_ready", 32'(s_ready), 1);
      chk("t1_fs", 32'(fs), (i == 1) ? 1 : 0);
      chk("t1_fe", 32'(fe), 0);
      chk("t1_tx", 32'(tx_active), 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    chk("t1_fe_end", 32'(fe), 1);
    chk("t1_fb", 32'(fb), 4);
    chk("t1_m_valid_end", 32'(m_valid), 0);
    chk("t1_tx_end", 32'(tx_active), 0);
    chk("t1_osr", 32'(osr), 1);

    // same frame, 5-cycle downstream stall
    rx_q.delete();
    s_valid = 1'b1;
    s_data  = 8'hB0;
    step();
    s_data = 8'hB1;
    step();
    m_ready = 1'b0;
    s_data  = 8'hB2;
    step();
    chk("t2_s_ready_drop", 32'(s_ready), 0);
    chk("t2_hold_b1", 32'(m_data), 32'h00B1);
    chk("t2_osr", 32'(osr), 0);
    s_data = 8'hB3;
    s_last = 1'b1;
    repeat (4) step();
    chk("t2_s_ready_low", 32'(s_ready), 0);
    chk("t2_hold_b1b", 32'(m_data), 32'h00B1);
    m_ready = 1'b1;
    step();
    chk("t2_b2_out", 32'(m_data), 32'h00B2);
    chk("t2_s_ready_up", 32'(s_ready), 1);
    chk("t2_stall", stall, STATS ? 5 : 0);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t2_b3_out", 32'(m_data), 32'h00B3);
    chk("t2_b3_last", 32'(m_last), 1);
    step();
    chk("t2_fe", 32'(fe), 1);
    chk("t2_fb", 32'(fb), 4);
    chk("t2_rx_n", rx_q.size(), 4);
    if (rx_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_rx_order", 32'(rx_q[i]),
            32'(8'hB0 + 8'(i)));
      end
    end
    chk("t2_stall_hold", stall, STATS ? 5 : 0);

    // single-beat frame
    s_data  = 8'hC5;
    s_last  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t3_tx_on", 32'(tx_active), 1);
    chk("t3_fs_pre", 32'(fs), 0);
    step();
    chk("t3_fs", 32'(fs), 1);
    chk("t3_fe", 32'(fe), 1);
    chk("t3_fb", 32'(fb), 1);
    chk("t3_tx_off", 32'(tx_active), 0);
    step();
    chk("t3_fs_clr", 32'(fs), 0);
    chk("t3_fe_clr", 32'(fe), 0);
    chk("t3_fb_hold", 32'(fb), 1);

    // 32-bit, LEN_WIDTH=4, 5 beats saturate at 15
    for (int i = 0; i < 5; i++) begin
      w_s_data  = 32'h1000_0000 + 32'(i);
      w_s_last  = (i == 4);
      w_s_valid = 1'b1;
      step();
      chk("t4_w_data", w_m_data, 32'h1000_0000 + 32'(i));
    end
    w_s_valid = 1'b0;
    w_s_last  = 1'b0;
    step();
    chk("t4_w_fe", 32'(w_fe), 1);
    chk("t4_w_fb", 32'(w_fb), 15);

    // stats_clear during a stall
    m_ready = 1'b0;
    s_data  = 8'hD0;
    s_last  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    chk("t5_stall_pre", stall, STATS ? 7 : 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_stall_clr", stall, 0);
    chk("t5_idle_clr", idle, 0);
    step();
    chk("t5_stall_1", stall, STATS ? 1 : 0);
    chk("t5_idle_0", idle, 0);
    step();
    chk("t5_stall_2", stall, STATS ? 2 : 0);
    m_ready = 1'b1;
    step();
    chk("t5_fe", 32'(fe), 1);
    chk("t5_fb", 32'(fb), 1);

    // reset mid-frame with 2 beats buffered
    s_valid = 1'b1;
    s_data  = 8'hE0;
    step();
    s_data = 8'hE1;
    step();
    m_ready = 1'b0;
    s_data  = 8'hE2;
    step();
    s_valid = 1'b0;
    chk("t6_tx_pre", 32'(tx_active), 1);
    chk("t6_full", 32'(s_ready), 0);
    rstn = 1'b0;
    #1;
    chk("t6_m_valid", 32'(m_valid), 0);
    chk("t6_tx", 32'(tx_active), 0);
    chk("t6_m_data", 32'(m_data), 0);
    chk("t6_fb", 32'(fb), 0);
    chk("t6_stall", stall, 0);
    #2 rstn = 1'b1;
    m_ready = 1'b1;
    s_data  = 8'hF7;
    s_last  = 1'b1;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t6_new_data", 32'(m_data), 32'h00F7);
    step();
    chk("t6_new_fs", 32'(fs), 1);
    chk("t6_new_fe", 32'(fe), 1);
    chk("t6_new_fb", 32'(fb), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
